dt1_memarb: RTL and testbench
=============================

// Module: dt1_memarb
// PURPOSE
//  Arbiter for a single unified memory port shared by instruction fetch (F stage) and data access (M stage).
//  Serialises the two requests, with data having priority, and holds each completed result until the pipeline advances.
//  Raises stall_mem while any request of the current pipeline cycle is unserved.
//  stall_mem is ORed with the hazard unit's StallF/StallD and with the pipeline-register enables at top level.
// PARAMETERS
//  AW   32  address width (byte address)
//  DW   32  data width; write strobe width is DW/8
// PORTS
//  clk        in   1      core clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  if_req     in   1      fetch request, held stable while stall_mem=1
//  if_addr    in   AW     fetch address (PCF)
//  if_rdata   out  DW     fetched instruction
//  dm_req     in   1      data request (load or store in M), held stable while stall_mem=1
//  dm_we      in   1      1=store, 0=load
//  dm_wstrb   in   DW/8   byte enables for stores
//  dm_addr    in   AW     data address (ALUResultM)
//  dm_wdata   in   DW     store data
//  dm_rdata   out  DW     load data
//  mem_valid  out  1      request valid to memory
//  mem_we     out  1      write enable to memory
//  mem_wstrb  out  DW/8   byte enables to memory (all zero for fetch/load)
//  mem_addr   out  AW     address to memory
//  mem_wdata  out  DW     write data to memory
//  mem_rdata  in   DW     read data, valid when mem_ready=1
//  mem_ready  in   1      transfer completes this cycle (may be high the same cycle as mem_valid)
//  stall_mem  out  1      1 = hold F/D/E/M/W pipeline registers this cycle
// BEHAVIOUR
//  Reset: state=IDLE, dm_done=if_done=0, held rdata regs=0. While rst_n=0, mem_valid=0 and stall_mem=0.
//  Pending: dm_pend=dm_req&~dm_done; if_pend=if_req&~if_done.
//  FSM states: IDLE, BUSY_D, BUSY_I.
//  Owner selection:
//    BUSY_D -> D; BUSY_I -> I.
//    IDLE   -> D if dm_pend, else I if if_pend, else none.
//  Memory outputs:
//    mem_valid = (state!=IDLE) | dm_pend | if_pend.
//    mem_* fields are muxed from the owner.
//    Fetch drives mem_we=0 and mem_wstrb=0. A load drives mem_wstrb=0.
//  Transfer with mem_valid & ~mem_ready: state <= BUSY_owner. The grant is locked; owner fields must not change.
//  Transfer with mem_valid & mem_ready:
//    owner's done flag <= 1; owner's rdata reg <= mem_rdata (store: reg unchanged); state <= IDLE.
//  Combinational completion term: dm_fin = dm_done | (owner==D & mem_valid & mem_ready); if_fin likewise.
//  stall_mem = (dm_req&~dm_fin) | (if_req&~if_fin).
//    This is a combinational path from mem_ready, by design.
//  Read data:
//    dm_rdata = dm_done ? held reg : mem_rdata.
//    if_rdata = if_done ? held reg : mem_rdata.
//    Data is bypassed in the completing cycle.
//  Advance: on any edge with stall_mem=0, both done flags clear to 0.
//  Latency with zero-wait memory:
//    fetch-only cycle: 0 stall cycles.
//    fetch + data: 1 stall cycle (D served first, then I).
//    Each memory wait state adds 1 stall cycle.
//  Boundaries:
//    Simultaneous requests: data always first, so the older instruction wins.
//    Requester drops req while locked: the transfer still completes; the result is discarded and the flag is set but ignored.
//    A done flag is also cleared if its req is low on an advance edge.
//    No requests: mem_valid=0, stall_mem=0, state stays IDLE.
//    Async reset mid-transfer: returns to IDLE immediately; the memory slave must tolerate an aborted request.
//    Hazard flush (FlushD/FlushE) does not affect this block. The fetch completes, then the flushed instruction is dropped downstream.
// TESTING
//  1. Reset: rst_n=0 while if_req=dm_req=1 -> mem_valid=0, stall_mem=0; release -> mem_valid=1 with owner D.
//  2. Fetch only, mem_ready tied 1, if_addr=0x100, mem_rdata=0x00500093 -> if_rdata=0x00500093 same cycle, stall_mem=0.
//  3. Load+fetch same cycle, zero-wait, dm_addr=0x2000 rdata 0xDEADBEEF.
//     cycle0: mem_addr=0x2000, stall_mem=1.
//     cycle1: mem_addr=if_addr, stall_mem=0, dm_rdata=0xDEADBEEF held.
//  4. Store dm_wstrb=4'b0011 with 2 wait states plus fetch -> 3 cycles on the D grant, grant locked, mem_wstrb=0011 throughout.
//     Then 1 fetch cycle; stall_mem=1 for 3 cycles total.
//  5. Fetch locked in BUSY_I (mem_ready=0) when dm_req rises -> owner stays I until ready, then D. No field glitch on mem_addr.
//  6. Assert rst_n=0 mid-wait in BUSY_D -> state IDLE and flags 0 asynchronously; after release the request reissues from scratch.

Source files
------------

// File: rtl/dt1_memarb.sv
// dt1_memarb: shares one memory port between instruction fetch and data access.
// Data has priority. Each completed result is held until the pipeline advances.
//
// state  | meaning
// IDLE   | no transfer in flight; owner picked from pending requests (D first)
// BUSY_D | data transfer waiting on mem_ready; grant locked to D
// BUSY_I | fetch transfer waiting on mem_ready; grant locked to I
module dt1_memarb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_wstrb,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} stateT;

  stateT         state;
  logic          dmDone, ifDone;
  logic [DW-1:0] dmHeld, ifHeld;
  logic          dmPend, ifPend;
  logic          ownerD, ownerI;
  logic          xferDone;
  logic          dmFin, ifFin;

  assign dmPend = dm_req & ~dmDone;
  assign ifPend = if_req & ~ifDone;

  // Owner selection: a busy state locks the grant, otherwise data wins.
  always_comb begin
    ownerD = 1'b0;
    ownerI = 1'b0;
    case (state)
      BUSY_D:  ownerD = 1'b1;
      BUSY_I:  ownerI = 1'b1;
      default: begin
        ownerD = dmPend;
        ownerI = ~dmPend & ifPend;
      end
    endcase
  end

  // Reset gates the request so the memory sees nothing while rst_n is low.
  assign mem_valid = rst_n & ((state != IDLE) | dmPend | ifPend);
  assign xferDone  = mem_valid & mem_ready;

  // Memory field mux; fetch and load never drive byte enables.
  always_comb begin
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ownerD) begin
      mem_we    = dm_we;
      mem_wstrb = dm_we ? dm_wstrb : '0;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (ownerI) begin
      mem_addr  = if_addr;
    end
  end

  // Completion includes the transfer finishing this cycle, so the stall can
  // drop in the same cycle mem_ready rises.
  assign dmFin     = dmDone | (ownerD & xferDone);
  assign ifFin     = ifDone | (ownerI & xferDone);
  assign stall_mem = rst_n & ((dm_req & ~dmFin) | (if_req & ~ifFin));

  // Results are bypassed from memory in the completing cycle, held afterwards.
  assign dm_rdata = dmDone ? dmHeld : mem_rdata;
  assign if_rdata = ifDone ? ifHeld : mem_rdata;

  // Arbiter FSM: lock grant on wait states, record completion, clear on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dmDone <= 1'b0;
      ifDone <= 1'b0;
      dmHeld <= '0;
      ifHeld <= '0;
    end else begin
      if (xferDone) begin
        state <= IDLE;
        if (ownerD) begin
          dmDone <= 1'b1;
          if (!dm_we) dmHeld <= mem_rdata;
        end
        if (ownerI) begin
          ifDone <= 1'b1;
          ifHeld <= mem_rdata;
        end
      end else if (mem_valid) begin
        state <= ownerD ? BUSY_D : BUSY_I;
      end
      // An advance edge retires both results; this overrides any set above.
      if (!stall_mem) begin
        dmDone <= 1'b0;
        ifDone <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dt1_memarb.sv
// tb_dt1_memarb: transaction-level check of the memory arbiter. Each pipeline
// cycle is modelled as a D segment (1+waits cycles) followed by an I segment,
// against a small word-addressed memory kept in the bench.
module tb_dt1_memarb;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_mem;

  int nChk = 0;
  int nBad = 0;

  logic [31:0] memArr [16];

  dt1_memarb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive requests, play the memory with the given wait
  // counts, and check every clock until the advance edge.
  task automatic runPipe(input bit doD, input bit doI, input bit we,
                         input logic [3:0] strb, input logic [31:0] dAddr,
                         input logic [31:0] iAddr, input logic [31:0] wdata,
                         input int wD, input int wI);
    int nD, nI, total;
    logic [31:0] dExp, iExp;
    nD    = doD ? wD + 1 : 0;
    nI    = doI ? wI + 1 : 0;
    total = (nD + nI == 0) ? 1 : nD + nI;
    dm_req = doD; if_req = doI; dm_we = we; dm_wstrb = strb;
    dm_addr = dAddr; dm_wdata = wdata; if_addr = iAddr;
    dExp = memArr[dAddr[5:2]];
    iExp = '0;
    for (int k = 0; k < total; k++) begin
      bit segD, segI, last;
      segD = doD && (k < nD);
      segI = doI && !segD;
      last = segD ? (k == nD - 1) : (segI ? (k == total - 1) : 1'b0);
      mem_ready = (segD || segI) ? last : 1'($urandom_range(0, 1));
      if (segD && last && !we) mem_rdata = dExp;
      else if (segI && last) begin
        iExp = memArr[iAddr[5:2]];
        mem_rdata = iExp;
      end else mem_rdata = $urandom;
      @(negedge clk);
      chk("valid", 64'(mem_valid), 64'(doD | doI));
      if (segD) begin
        chk("d_addr", 64'(mem_addr), 64'(dAddr));
        chk("d_we", 64'(mem_we), 64'(we));
        chk("d_strb", 64'(mem_wstrb), we ? 64'(strb) : 64'd0);
        if (we) chk("d_wdata", 64'(mem_wdata), 64'(wdata));
      end
      if (segI) begin
        chk("i_addr", 64'(mem_addr), 64'(iAddr));
        chk("i_we", 64'(mem_we), 64'd0);
        chk("i_strb", 64'(mem_wstrb), 64'd0);
      end
      chk("stall", 64'(stall_mem), 64'(k != total - 1));
      if (k == total - 1) begin
        if (doD && !we) chk("dm_rdata", 64'(dm_rdata), 64'(dExp));
        if (doI) chk("if_rdata", 64'(if_rdata), 64'(iExp));
      end
      @(posedge clk);
      if (segD && last && we)
        for (int b = 0; b < 4; b++)
          if (strb[b]) memArr[dAddr[5:2]][8*b +: 8] = wdata[8*b +: 8];
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) memArr[i] = $urandom;
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_wstrb = '0;
    dm_addr = 32'h2004; if_addr = 32'h108; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset with both requests high: nothing goes out.
    @(negedge clk);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_stall", 64'(stall_mem), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    runPipe(1, 1, 0, 4'h0, 32'h2004, 32'h108, 32'h0, 0, 0);

    // Fetch only, zero wait.
    memArr[0] = 32'h0050_0093;
    runPipe(0, 1, 0, 4'h0, 32'h0, 32'h100, 32'h0, 0, 0);

    // Load + fetch, zero wait.
    memArr[0] = 32'hDEAD_BEEF;
    runPipe(1, 1, 0, 4'h0, 32'h2000, 32'h104, 32'h0, 0, 0);

    // Store with two wait states plus fetch.
    runPipe(1, 1, 1, 4'b0011, 32'h2010, 32'h110, 32'hA5A5_1234, 2, 0);

    // Idle cycle.
    runPipe(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Fetch locked in BUSY_I when a data request arrives.
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h108; mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    chk("lk_addr0", 64'(mem_addr), 64'h108);
    chk("lk_stall0", 64'(stall_mem), 64'd1);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200C;
    @(negedge clk);
    chk("lk_addr1", 64'(mem_addr), 64'h108);
    chk("lk_we1", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = memArr[2];
    @(negedge clk);
    chk("lk_addr2", 64'(mem_addr), 64'h108);
    chk("lk_ifrd2", 64'(if_rdata), 64'(memArr[2]));
    chk("lk_stall2", 64'(stall_mem), 64'd1);
    @(posedge clk); #1;
    mem_rdata = memArr[3];
    @(negedge clk);
    chk("lk_addr3", 64'(mem_addr), 64'h200C);
    chk("lk_stall3", 64'(stall_mem), 64'd0);
    chk("lk_dmrd3", 64'(dm_rdata), 64'(memArr[3]));
    chk("lk_ifrd3", 64'(if_rdata), 64'(memArr[2]));
    @(posedge clk); #1;

    // Async reset while waiting in BUSY_D.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2018; if_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(mem_valid), 64'd0);
    chk("ar_stall", 64'(stall_mem), 64'd0);
    dm_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle", 64'(mem_valid), 64'd0);
    @(posedge clk); #1;
    runPipe(1, 0, 0, 4'h0, 32'h2018, 32'h0, 32'h0, 1, 0);

    // Randomised pipeline traffic.
    for (int n = 0; n < 200; n++) begin
      bit rd, ri, rw;
      logic [3:0] rs;
      rd = ($urandom_range(0, 9) < 7);
      ri = ($urandom_range(0, 9) < 8);
      rw = 1'($urandom_range(0, 1));
      rs = 4'($urandom_range(1, 15));
      runPipe(rd, ri, rw, rs,
              32'h2000 | (32'($urandom_range(0, 15)) << 2),
              32'h100 | (32'($urandom_range(0, 15)) << 2),
              $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
